regfile_debug_port: RTL and testbench
=====================================

Name: regfile_debug_port

Overview:
Debug-side reader/writer for the integer register file of the multi-cycle core. While the core is halted, a debug request either dumps all registers as a valid/ready word stream, or loads x1..x(N-1) from an incoming stream. The block drives the register file's second read port and its write port through a mux owned by the core top. It captures read data on posedge clk. It holds write controls stable for a full cycle, so the register file's negedge write lands mid-cycle.

Parameters:
XLEN, 32, data width of each register and of both streams
REG_COUNT, 32, number of architectural registers; power of two, at most 32
AW, $clog2(REG_COUNT), index width

Ports:
clk  in  1  clock; all block state updates on posedge
rst  in  1  reset, asynchronous, active-high
core_halted  in  1  core is stopped; start requests are honoured only when high
dump_start  in  1  one-cycle request to dump all registers
load_start  in  1  one-cycle request to load x1..x(N-1)
abort  in  1  synchronous cancel of any operation in progress
busy  out  1  operation in progress (state != IDLE)
done  out  1  one-cycle pulse when an operation completes normally
out_valid  out  1  dump word available
out_ready  in  1  consumer accepts dump word
out_data  out  XLEN  dump word
out_idx  out  AW  register index of out_data
in_valid  in  1  load word available
in_ready  out  1  block accepts load word
in_data  in  XLEN  load word
rf_rd_addr  out  AW  register file read address (combinational read)
rf_rd_data  in  XLEN  register file read data
rf_we  out  1  register file write enable (registered)
rf_wr_addr  out  AW  register file write address (registered)
rf_wr_data  out  XLEN  register file write data (registered)

Behaviour:
- Reset values: state=IDLE, idx=0; busy, done, out_valid, in_ready, rf_we = 0; out_data, out_idx, rf_wr_addr, rf_wr_data, rf_rd_addr = 0.
- States: IDLE, DUMP_READ, DUMP_SEND, LOAD_WAIT, LOAD_WRITE, DONE.
- IDLE transitions:
  - dump_start & core_halted -> DUMP_READ, idx=0.
  - load_start & core_halted -> LOAD_WAIT, idx=1.
  - Both starts high in the same cycle: dump wins.
  - Starts are ignored when core_halted=0 or when not in IDLE.
- DUMP_READ:
  - rf_rd_addr=idx.
  - At the next posedge: out_data<=rf_rd_data, out_idx<=idx, out_valid<=1, go to DUMP_SEND.
  - x0 reads as 0 from the register file and is emitted as-is.
- DUMP_SEND:
  - out_valid, out_data and out_idx are held stable until out_valid & out_ready.
  - On handshake: out_valid<=0. If idx==REG_COUNT-1 go to DONE, else idx++ and go to DUMP_READ.
  - Throughput is at most 1 word per 2 cycles. out_ready may be high before out_valid.
- LOAD_WAIT:
  - in_ready=1 (combinational from state).
  - On in_valid: rf_wr_data<=in_data, rf_wr_addr<=idx, rf_we<=1, go to LOAD_WRITE.
- LOAD_WRITE:
  - rf_we is high for exactly this one cycle; the register file commits at the negedge.
  - Next posedge: rf_we<=0. If idx==REG_COUNT-1 go to DONE, else idx++ and go to LOAD_WAIT.
  - Load consumes exactly REG_COUNT-1 words; x0 is never addressed.
- DONE: done=1 for one cycle, then IDLE.
- rf_rd_addr is 0 in every state except DUMP_READ.
- abort (any non-IDLE state):
  - Next state is IDLE; out_valid, in_ready and rf_we drop at that posedge; done is not pulsed.
  - A write already asserted in LOAD_WRITE has completed at the preceding negedge and is not undone.
- core_halted falling mid-operation has no effect; the operation finishes or is aborted.
- Asynchronous rst mid-operation returns all outputs to their reset values immediately.
- idx never wraps: the terminal checks compare against REG_COUNT-1 before incrementing.

Decomposition:
- Shared package riscv_pkg: XLEN, REG_COUNT, reg_idx_t (logic [AW-1:0]), dbg_state_e enum of the six states.
- No sub-module; a single FSM with an index counter and output registers.

Test Plan:
1. Preload the register file with x_i = 0x1000_0000+i, core_halted=1, dump_start, out_ready=1 -> 32 words, out_idx 0..31; x0 word = 0x0, word 5 = 0x1000_0005; done pulses once; busy low the cycle after done.
2. Dump with out_ready toggling 1-0-0-1 -> out_data/out_idx stay stable while out_valid & !out_ready; no word lost or duplicated; 32 words total.
3. load_start, stream 31 words 0xA5A5_0001..0xA5A5_001F with random in_valid gaps -> rf_we pulses 31 times at addrs 1..31; follow-up dump returns x0=0, x31=0xA5A5_001F.
4. dump_start and load_start together with core_halted=1 -> dump executes; with core_halted=0 -> busy stays 0 and no rf_we.
5. abort during LOAD_WAIT after 10 words -> IDLE next cycle, no done; x1..x10 updated, x11 unchanged.
6. Assert rst during DUMP_SEND at idx=7 -> out_valid=0, busy=0 immediately; a new dump after reset restarts at out_idx=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and debug-port types
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int AW        = $clog2(REG_COUNT);

  typedef logic [AW-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMP_READ,
    ST_DUMP_SEND,
    ST_LOAD_WAIT,
    ST_LOAD_WRITE,
    ST_DONE
  } dbg_state_e;

endpackage

// File: rtl/regfile_debug_port.sv
// rtl/regfile_debug_port.sv - halted-core register file dump/load engine
// Drives the regfile's second read port and its write port through the core-top mux.
module regfile_debug_port
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int REG_COUNT = riscv_pkg::REG_COUNT,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_halted,
  input  logic            dump_start,
  input  logic            load_start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  output logic [AW-1:0]   rf_rd_addr,
  input  logic [XLEN-1:0] rf_rd_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(REG_COUNT - 1);

  dbg_state_e      r_state;
  logic [AW-1:0]   r_idx;
  logic            r_done;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_data;
  logic [AW-1:0]   r_out_idx;
  logic            r_we;
  logic [AW-1:0]   r_wr_addr;
  logic [XLEN-1:0] r_wr_data;
  logic            w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else if (abort && r_state != ST_IDLE) begin
      // A write already committed at the previous negedge stays in the regfile.
      r_state     <= ST_IDLE;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dump_start && core_halted) begin
            r_state <= ST_DUMP_READ;
            r_idx   <= '0;
          end else if (load_start && core_halted) begin
            r_state <= ST_LOAD_WAIT;
            r_idx   <= AW'(1);
          end
        end
        ST_DUMP_READ: begin
          r_out_data  <= rf_rd_data;
          r_out_idx   <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= ST_DUMP_SEND;
        end
        ST_DUMP_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= ST_DUMP_READ;
            end
          end
        end
        ST_LOAD_WAIT: begin
          if (in_valid) begin
            r_wr_data <= in_data;
            r_wr_addr <= r_idx;
            r_we      <= 1'b1;
            r_state   <= ST_LOAD_WRITE;
          end
        end
        ST_LOAD_WRITE: begin
          r_we <= 1'b0;
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + AW'(1);
            r_state <= ST_LOAD_WAIT;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign in_ready   = (r_state == ST_LOAD_WAIT);
  assign rf_rd_addr = (r_state == ST_DUMP_READ) ? r_idx : '0;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_idx    = r_out_idx;
  assign rf_we      = r_we;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;

endmodule

// File: tb/tb_regfile_debug_port.sv
// tb/tb_regfile_debug_port.sv - self-checking bench for regfile_debug_port
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst, core_halted, dump_start, load_start, abort;
  logic        busy, done, out_valid, out_ready, in_valid, in_ready, rf_we;
  logic [31:0] out_data, in_data, rf_rd_data, rf_wr_data;
  logic [4:0]  out_idx, rf_rd_addr, rf_wr_addr;

  regfile_debug_port dut (
    .clk(clk), .rst(rst), .core_halted(core_halted),
    .dump_start(dump_start), .load_start(load_start), .abort(abort),
    .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, negedge write, x0 hardwired to zero.
  logic        do_preload;
  logic [31:0] rf_mem [32];
  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'h0 : rf_mem[rf_rd_addr];
  always @(negedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + i;
    end else if (rf_we && rf_wr_addr != 5'd0) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected register contents and stream ordering.
  logic [31:0] model_rf [32];
  logic [31:0] dump_data [32];
  int          dump_n = 0, load_n = 1, words = 0, ld_acc = 0, done_cnt = 0, we_cnt = 0;
  logic        pend = 0, have_hold = 0, prev_done = 0;
  logic [4:0]  pend_addr, hold_idx;
  logic [31:0] pend_data, hold_data;

  always @(negedge clk) begin
    #2;
    if (do_preload) begin
      for (int i = 0; i < 32; i++) model_rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    end
    if (rst) begin
      pend = 0; have_hold = 0; prev_done = 0;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    end else begin
      chk("rf_we_timing", {31'h0, rf_we}, {31'h0, pend});
      if (pend && rf_we) begin
        chk("rf_wr_addr", {27'h0, rf_wr_addr}, {27'h0, pend_addr});
        chk("rf_wr_data", rf_wr_data, pend_data);
        we_cnt++;
      end
      pend = 0;
      if (have_hold) begin
        chk("hold_valid", {31'h0, out_valid}, 32'h1);
        chk("hold_data", out_data, hold_data);
        chk("hold_idx", {27'h0, out_idx}, {27'h0, hold_idx});
      end
      if (prev_done) begin
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        chk("done_one_cycle", {31'h0, done}, 32'h0);
      end
      if (out_valid || in_ready) chk("rd_addr_idle", {27'h0, rf_rd_addr}, 32'h0);
      if (done) done_cnt++;
      if (!busy && core_halted && dump_start) dump_n = 0;
      else if (!busy && core_halted && load_start) load_n = 1;
      if (out_valid && out_ready && !abort) begin
        chk("dump_idx", {27'h0, out_idx}, dump_n);
        if (dump_n < 32) chk("dump_data", out_data, model_rf[dump_n]);
        dump_data[out_idx] = out_data;
        dump_n++;
        words++;
      end
      have_hold = out_valid && !out_ready && !abort;
      hold_data = out_data;
      hold_idx  = out_idx;
      if (in_valid && in_ready && !abort) begin
        chk("load_in_range", (load_n >= 1 && load_n <= 31) ? 32'h1 : 32'h0, 32'h1);
        pend      = 1;
        pend_addr = load_n[4:0];
        pend_data = in_data;
        if (load_n >= 1 && load_n <= 31) model_rf[load_n] = in_data;
        load_n++;
        ld_acc++;
      end
      prev_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic pulse_dump();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  int w0, d0, we0, ld0, n;

  initial begin
    rst = 1'b1; core_halted = 1'b0; dump_start = 1'b0; load_start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 32'h0; do_preload = 1'b1;
    step(); step();
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
    chk("reset_rf_we", {31'h0, rf_we}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_idx", {27'h0, out_idx}, 32'h0);
    chk("reset_wr_addr", {27'h0, rf_wr_addr}, 32'h0);
    chk("reset_wr_data", rf_wr_data, 32'h0);
    chk("reset_rd_addr", {27'h0, rf_rd_addr}, 32'h0);
    do_preload = 1'b0; rst = 1'b0; core_halted = 1'b1;
    step();

    // Full dump, consumer always ready
    w0 = words; d0 = done_cnt; out_ready = 1'b1;
    pulse_dump();
    chk("t1_busy", {31'h0, busy}, 32'h1);
    wait_idle(200);
    chk("t1_words", words - w0, 32);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_x0", dump_data[0], 32'h0);
    chk("t1_x5", dump_data[5], 32'h1000_0005);
    chk("t1_x31", dump_data[31], 32'h1000_001F);

    // Dump with backpressure 1-0-0-1
    w0 = words; d0 = done_cnt;
    pulse_dump();
    n = 0;
    while (busy && n < 400) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    chk("t2_timeout", {31'h0, busy}, 32'h0);
    chk("t2_words", words - w0, 32);
    chk("t2_done", done_cnt - d0, 1);
    out_ready = 1'b1;

    // Load 31 words with random gaps
    ld0 = ld_acc; we0 = we_cnt; d0 = done_cnt;
    pulse_load();
    n = 0;
    while (busy && n < 400) begin
      in_valid = (ld_acc - ld0 < 31) && ($urandom_range(0, 2) != 0);
      in_data  = 32'hA5A5_0001 + (ld_acc - ld0);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("t3_timeout", {31'h0, busy}, 32'h0);
    chk("t3_writes", we_cnt - we0, 31);
    chk("t3_done", done_cnt - d0, 1);
    pulse_dump();
    wait_idle(200);
    chk("t3_x0", dump_data[0], 32'h0);
    chk("t3_x1", dump_data[1], 32'hA5A5_0001);
    chk("t3_x31", dump_data[31], 32'hA5A5_001F);

    // Simultaneous starts: dump wins; ignored while running
    w0 = words; we0 = we_cnt;
    dump_start = 1'b1; load_start = 1'b1;
    step();
    dump_start = 1'b0; load_start = 1'b0;
    wait_idle(200);
    chk("t4_words", words - w0, 32);
    chk("t4_no_write", we_cnt - we0, 0);
    core_halted = 1'b0;
    dump_start = 1'b1; load_start = 1'b1;
    step();
    dump_start = 1'b0; load_start = 1'b0;
    chk("t4_not_halted_busy", {31'h0, busy}, 32'h0);
    step(); step();
    chk("t4_not_halted_busy2", {31'h0, busy}, 32'h0);
    chk("t4_not_halted_we", we_cnt - we0, 0);
    core_halted = 1'b1;

    // Abort in LOAD_WAIT after 10 words
    ld0 = ld_acc; we0 = we_cnt; d0 = done_cnt;
    pulse_load();
    n = 0;
    while (ld_acc - ld0 < 10 && n < 200) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 32'hC3C3_0001 + (ld_acc - ld0);
      step();
      n++;
    end
    in_valid = 1'b0;
    step();
    chk("t5_in_ready", {31'h0, in_ready}, 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_idle", {31'h0, busy}, 32'h0);
    chk("t5_abort_in_ready", {31'h0, in_ready}, 32'h0);
    step();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_writes", we_cnt - we0, 10);
    pulse_dump();
    wait_idle(200);
    chk("t5_x1", dump_data[1], 32'hC3C3_0001);
    chk("t5_x10", dump_data[10], 32'hC3C3_000A);
    chk("t5_x11", dump_data[11], 32'hA5A5_000B);

    // Async reset while holding word 7
    out_ready = 1'b1;
    pulse_dump();
    n = 0;
    while (!(out_valid && out_idx == 5'd7) && n < 100) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("t6_reach_idx7", {27'h0, out_idx}, 32'd7);
    step();
    chk("t6_holding", {31'h0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_idx", {27'h0, out_idx}, 32'h0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    w0 = words;
    pulse_dump();
    wait_idle(200);
    chk("t6_words", words - w0, 32);
    chk("t6_x7", dump_data[7], 32'hC3C3_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
